boot_stream_unpacker: RTL and testbench
=======================================

// Module: boot_stream_unpacker
// PURPOSE
//  Upstream feeder for GameLoader. Accepts 32-bit ROM words from the control module's host_bootdata
//  req/ack port and buffers them in an internal word FIFO. Unpacks each word MSB-first into bytes and
//  discards everything before the first 0x4E ('N' of the iNES header). Delivers the remaining bytes
//  as paced single-cycle strobes to the loader. Words beyond rom_size are acknowledged but dropped.
// PARAMETERS
//  FIFO_DEPTH_LOG2  4    word FIFO depth = 2**FIFO_DEPTH_LOG2 (16 words)
//  STROBE_GAP       64   minimum clk cycles from one byte_strobe rising to the next (>=2)
//  SYNC_BYTE        8'h4E  first byte forwarded; all earlier bytes discarded
// PORTS
//  clk              in   1   system clock; all logic rising-edge
//  reset_n          in   1   asynchronous active-low reset
//  loader_reset     in   1   synchronous restart (active high), same effect as reset
//  rom_size         in   32  byte count to accept; sampled at each word accept
//  host_bootdata    in   32  boot word, byte 3 ([31:24]) sent first
//  host_bootdata_req in  1   word available (level)
//  host_bootdata_ack out 1   4-phase acknowledge
//  byte_ready       in   1   consumer may accept a byte
//  byte_data        out  8   byte to loader; stable from strobe until next strobe
//  byte_strobe      out  1   one-cycle pulse, byte_data valid
//  synced           out  1   SYNC_BYTE found, streaming
//  fifo_full        out  1   word FIFO full
//  bytes_loaded     out  32  bytes accepted into FIFO (counts in 4s)
//  words_dropped    out  16  words acked beyond rom_size, saturating
// BEHAVIOUR
//  Reset (reset_n=0 async, or loader_reset=1 at edge): ack=0, byte_strobe=0, byte_data=0, synced=0,
//   FIFO empty, fifo_full=0, bytes_loaded=0, words_dropped=0, gap counter=0, byte index=0, HS=IDLE.
//  Handshake FSM (HS): IDLE -> ACK when req=1 and FIFO not full; at that edge the word is written
//   if bytes_loaded < rom_size (bytes_loaded += 4), else dropped (words_dropped += 1, saturate 16'hFFFF).
//   ACK: ack=1; stays until req=0, then -> IDLE with ack=0 next cycle. One word per req pulse.
//   req=1 with FIFO full: remain IDLE, ack=0, until a slot frees; never overwrite.
//  Unpack: head word read into shift reg when reg empty; byte index 0..3 selects [31:24],[23:16],
//   [15:8],[7:0]. After index 3 next word loaded; index wraps to 0. FIFO empty -> no output, no error.
//  Sync FSM: SYNC: each byte consumed internally at 1 byte/clk, no strobe, until byte==SYNC_BYTE;
//   that byte is emitted (strobe) and state -> STREAM, synced=1. SYNC persists across words.
//  STREAM: byte emitted when byte available, byte_ready=1 and gap counter=0. Strobe cycle: byte_data
//   updated, byte_strobe=1, gap counter loads STROBE_GAP-1 and decrements to 0. Latency: word
//   written -> first eligible strobe in <=3 clk when gap expired and ready.
//  Simultaneous FIFO write and read in one cycle allowed; occupancy unchanged; full/empty exact.
//  byte_ready low holds the byte; gap counter keeps counting.
//  loader_reset mid-stream: all buffered data discarded, next accepted word restarts in SYNC.
//   An ack in progress is dropped to 0; host reissues req.
//  rom_size not multiple of 4: last partial word accepted whole (comparison is bytes_loaded<rom_size).
//  rom_size=0: every word dropped, no strobes ever.
// TESTING
//  Reset: pulse reset_n low mid-ack -> all outputs zero immediately, ack=0 asynchronously.
//  Sync: rom_size=16, words 0x124E4553,0x1A020100 -> strobes 4E,45,53,1A,02,01,00; 0x12 never emitted;
//   strobes spaced exactly 64 clk with byte_ready=1.
//  Truncation: rom_size=8, send 3 words -> 3 acks, bytes_loaded=8, words_dropped=1, 8-byte stream max.
//  Back-pressure: byte_ready=0, send 17 words -> 16 acked, fifo_full=1, 17th req unacked; raise
//   byte_ready -> 17th acked after a word drains, byte order intact.
//  Restart: loader_reset during STREAM -> synced=0, FIFO empty; new words 0x4E45531A -> 4E first.
//  Hold: byte_ready low 500 clk after strobe -> next strobe the cycle after ready rises (gap expired).

Source files
------------

// File: rtl/boot_stream_unpacker.sv
// boot_stream_unpacker
//   Sits in front of the game loader. It takes 32-bit ROM words from the
//   host_bootdata req/ack port and holds them in a small word FIFO. Each
//   word is unpacked MSB byte first. Every byte before the first SYNC_BYTE
//   is thrown away. The bytes from SYNC_BYTE onward go to the loader as
//   single-cycle strobes, at least STROBE_GAP clocks apart. Words that
//   arrive past rom_size are still acknowledged, then dropped and counted.
//
//   Ports
//     clk, reset_n       clock, asynchronous active-low reset
//     loader_reset       synchronous restart, same effect as reset
//     rom_size           number of bytes to accept (sampled at each accept)
//     host_bootdata*     4-phase word handshake, host side
//     byte_ready         the loader can take a byte
//     byte_data/strobe   byte to the loader, with its one-cycle valid pulse
//     synced             SYNC_BYTE has been found and streaming is active
//     fifo_full          word FIFO is full
//     bytes_loaded       bytes accepted into the FIFO (steps of 4)
//     words_dropped      words acknowledged past rom_size, saturating
//
//   state      | meaning
//   HS_IDLE    | waiting for req with a free slot (or a word to drop)
//   HS_ACK     | ack high, waiting for the host to drop req
//   SY_SYNC    | discarding bytes at 1/clk until SYNC_BYTE is seen
//   SY_STREAM  | forwarding bytes, paced by the gap counter and byte_ready
module boot_stream_unpacker #(
   parameter int          FIFO_DEPTH_LOG2 = 4,
   parameter int          STROBE_GAP      = 64,
   parameter logic [7:0]  SYNC_BYTE       = 8'h4E
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        loader_reset,
   input  logic [31:0] rom_size,
   input  logic [31:0] host_bootdata,
   input  logic        host_bootdata_req,
   output logic        host_bootdata_ack,
   input  logic        byte_ready,
   output logic [7:0]  byte_data,
   output logic        byte_strobe,
   output logic        synced,
   output logic        fifo_full,
   output logic [31:0] bytes_loaded,
   output logic [15:0] words_dropped
);

   localparam int L     = FIFO_DEPTH_LOG2;
   localparam int DEPTH = 2 ** L;
   localparam int GW    = $clog2(STROBE_GAP);

   typedef enum logic { HS_IDLE, HS_ACK }     hs_t;
   typedef enum logic { SY_SYNC, SY_STREAM }  sy_t;

   hs_t            hs_q, hs_d;
   sy_t            sy_q, sy_d;
   logic [31:0]    fifo_mem [DEPTH];
   logic [L-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [L:0]     count_q, count_d;
   logic [1:0]     idx_q, idx_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [7:0]     data_q, data_d;
   logic           strobe_q, strobe_d;
   logic [31:0]    bl_q, bl_d;
   logic [15:0]    wd_q, wd_d;
   logic           wr_en, rd_en, emit, advance;
   logic [31:0]    head;
   logic [7:0]     cur_byte;

   // The head word is read in place and popped only after its last byte is
   // consumed, so the word being unpacked keeps its FIFO slot.
   assign head = fifo_mem[rd_ptr_q];

   always_comb begin
      case (idx_q)
         2'd0:    cur_byte = head[31:24];
         2'd1:    cur_byte = head[23:16];
         2'd2:    cur_byte = head[15:8];
         default: cur_byte = head[7:0];
      endcase
   end

   always_comb begin
      hs_d     = hs_q;
      sy_d     = sy_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      bl_d     = bl_q;
      wd_d     = wd_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      emit     = 1'b0;
      advance  = 1'b0;

      case (hs_q)
         HS_IDLE: begin
            if (host_bootdata_req && (count_q != (L+1)'(DEPTH))) begin
               hs_d = HS_ACK;
               if (bl_q < rom_size) begin
                  wr_en = 1'b1;
                  bl_d  = bl_q + 32'd4;
               end else if (wd_q != 16'hFFFF) begin
                  wd_d = wd_q + 16'd1;
               end
            end
         end
         default: begin
            if (!host_bootdata_req) hs_d = HS_IDLE;
         end
      endcase

      if (count_q != '0) begin
         if (sy_q == SY_SYNC) begin
            if (cur_byte == SYNC_BYTE) begin
               // The sync byte is held until the loader can take it.
               if (byte_ready) begin
                  emit = 1'b1;
                  sy_d = SY_STREAM;
               end
            end else begin
               advance = 1'b1;
            end
         end else if (byte_ready && (gap_q == '0)) begin
            emit = 1'b1;
         end
      end

      if (emit) begin
         advance  = 1'b1;
         strobe_d = 1'b1;
         data_d   = cur_byte;
         gap_d    = GW'(STROBE_GAP - 1);
      end else if (gap_q != '0) begin
         gap_d = gap_q - GW'(1);
      end

      if (advance) begin
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) rd_en = 1'b1;
      end

      if (wr_en) wr_ptr_d = wr_ptr_q + L'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + L'(1);
      if (wr_en && !rd_en)      count_d = count_q + (L+1)'(1);
      else if (rd_en && !wr_en) count_d = count_q - (L+1)'(1);

      if (loader_reset) begin
         hs_d     = HS_IDLE;
         sy_d     = SY_SYNC;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         idx_d    = '0;
         gap_d    = '0;
         data_d   = '0;
         strobe_d = 1'b0;
         bl_d     = '0;
         wd_d     = '0;
         wr_en    = 1'b0;
         rd_en    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_q     <= HS_IDLE;
         sy_q     <= SY_SYNC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         idx_q    <= '0;
         gap_q    <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         bl_q     <= '0;
         wd_q     <= '0;
      end else begin
         hs_q     <= hs_d;
         sy_q     <= sy_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         bl_q     <= bl_d;
         wd_q     <= wd_d;
      end
   end

   // Storage only; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= host_bootdata;
   end

   assign host_bootdata_ack = (hs_q == HS_ACK);
   assign byte_data         = data_q;
   assign byte_strobe       = strobe_q;
   assign synced            = (sy_q == SY_STREAM);
   assign fifo_full         = (count_q == (L+1)'(DEPTH));
   assign bytes_loaded      = bl_q;
   assign words_dropped     = wd_q;

endmodule

// File: tb/tb_boot_stream_unpacker.sv
module tb_boot_stream_unpacker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        loader_reset = 1'b0;
   logic [31:0] rom_size = '0;
   logic [31:0] host_bootdata = '0;
   logic        host_bootdata_req = 1'b0;
   logic        host_bootdata_ack;
   logic        byte_ready = 1'b0;
   logic [7:0]  byte_data;
   logic        byte_strobe;
   logic        synced;
   logic        fifo_full;
   logic [31:0] bytes_loaded;
   logic [15:0] words_dropped;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [7:0] sq[$];
   int         st[$];
   logic [7:0] exp_q[$];

   boot_stream_unpacker dut (
      .clk(clk), .reset_n(reset_n), .loader_reset(loader_reset),
      .rom_size(rom_size), .host_bootdata(host_bootdata),
      .host_bootdata_req(host_bootdata_req), .host_bootdata_ack(host_bootdata_ack),
      .byte_ready(byte_ready), .byte_data(byte_data), .byte_strobe(byte_strobe),
      .synced(synced), .fifo_full(fifo_full), .bytes_loaded(bytes_loaded),
      .words_dropped(words_dropped)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (byte_strobe) begin
         sq.push_back(byte_data);
         st.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w, output bit acked);
      acked = 1'b0;
      @(negedge clk);
      host_bootdata     = w;
      host_bootdata_req = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (host_bootdata_ack) begin acked = 1'b1; break; end
      end
      host_bootdata_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!host_bootdata_ack) break;
      end
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sq.size() >= n) break;
         @(negedge clk);
      end
      chk(tag, sq.size(), n);
   endtask

   task automatic restart();
      @(negedge clk);
      loader_reset = 1'b1;
      @(negedge clk);
      loader_reset = 1'b0;
      sq.delete();
      st.delete();
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_count"}, sq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < sq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), sq[i], exp_q[i]);
   endtask

   bit a;
   int nack;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", host_bootdata_ack, 0);
      chk("rst_strobe", byte_strobe, 0);
      chk("rst_data", byte_data, 0);
      chk("rst_synced", synced, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_bl", bytes_loaded, 0);
      chk("rst_wd", words_dropped, 0);
      reset_n = 1'b1;

      // async reset in the middle of an ack
      rom_size = 32'd16;
      @(negedge clk);
      host_bootdata     = 32'h4E000000;
      host_bootdata_req = 1'b1;
      for (int i = 0; i < 10 && !host_bootdata_ack; i++) @(negedge clk);
      chk("midack_ack_seen", host_bootdata_ack, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_ack", host_bootdata_ack, 0);
      chk("async_bl", bytes_loaded, 0);
      host_bootdata_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      sq.delete(); st.delete();

      // sync search and strobe spacing
      byte_ready = 1'b1;
      rom_size   = 32'd16;
      send_word(32'h124E4553, a); chk("sync_ack0", a, 1);
      send_word(32'h1A020100, a); chk("sync_ack1", a, 1);
      wait_bytes("sync_nbytes", 7, 1000);
      repeat (150) @(negedge clk);
      exp_q = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h02, 8'h01, 8'h00};
      cmp_stream("sync");
      for (int i = 1; i < st.size(); i++)
         chk($sformatf("gap%0d", i), st[i] - st[i-1], 64);
      chk("sync_synced", synced, 1);
      chk("sync_bl", bytes_loaded, 8);

      // truncation at rom_size
      restart();
      rom_size = 32'd8;
      nack = 0;
      send_word(32'h4E010203, a); nack += int'(a);
      send_word(32'h04050607, a); nack += int'(a);
      send_word(32'h08090A0B, a); nack += int'(a);
      chk("trunc_acks", nack, 3);
      chk("trunc_bl", bytes_loaded, 8);
      chk("trunc_wd", words_dropped, 1);
      wait_bytes("trunc_nbytes", 8, 1000);
      repeat (150) @(negedge clk);
      exp_q = '{8'h4E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      cmp_stream("trunc");

      // back-pressure: fill the FIFO with the loader stalled
      restart();
      rom_size   = 32'd1000;
      byte_ready = 1'b0;
      exp_q.delete();
      nack = 0;
      for (int i = 0; i < 16; i++) begin
         logic [31:0] w;
         w = (i == 0) ? 32'h4E414243
                      : {8'(i*4), 8'(i*4+1), 8'(i*4+2), 8'(i*4+3)};
         for (int k = 3; k >= 0; k--) exp_q.push_back(w[k*8 +: 8]);
         send_word(w, a); nack += int'(a);
      end
      chk("bp_acks16", nack, 16);
      chk("bp_full", fifo_full, 1);
      @(negedge clk);
      host_bootdata     = 32'h40414243;
      host_bootdata_req = 1'b1;
      repeat (20) @(negedge clk);
      chk("bp_17_blocked", host_bootdata_ack, 0);
      chk("bp_no_strobe", sq.size(), 0);
      byte_ready = 1'b1;
      for (int i = 0; i < 400 && !host_bootdata_ack; i++) @(negedge clk);
      chk("bp_17_acked", host_bootdata_ack, 1);
      host_bootdata_req = 1'b0;
      for (int k = 3; k >= 0; k--) exp_q.push_back(8'(8'h40 + k[7:0] ^ 8'h03));
      wait_bytes("bp_nbytes", 68, 5000);
      repeat (150) @(negedge clk);
      cmp_stream("bp");
      chk("bp_full_after", fifo_full, 0);

      // loader_reset during streaming
      restart();
      rom_size = 32'd100;
      send_word(32'h4E010203, a);
      send_word(32'h04050607, a);
      wait_bytes("rs_pre", 2, 300);
      chk("rs_pre_synced", synced, 1);
      restart();
      chk("rs_synced", synced, 0);
      chk("rs_full", fifo_full, 0);
      chk("rs_bl", bytes_loaded, 0);
      repeat (100) @(negedge clk);
      chk("rs_quiet", sq.size(), 0);
      send_word(32'h4E45531A, a);
      wait_bytes("rs_nbytes", 4, 400);
      repeat (100) @(negedge clk);
      exp_q = '{8'h4E, 8'h45, 8'h53, 8'h1A};
      cmp_stream("rs");

      // hold: ready low well past the gap, strobe right after it rises
      restart();
      send_word(32'h4E010203, a);
      for (int i = 0; i < 50 && sq.size() == 0; i++) @(negedge clk);
      byte_ready = 1'b0;
      chk("hold_first", sq.size(), 1);
      repeat (500) @(negedge clk);
      chk("hold_none", sq.size(), 1);
      byte_ready = 1'b1;
      @(negedge clk);
      chk("hold_strobe", byte_strobe, 1);
      chk("hold_data", byte_data, 8'h01);

      // rom_size = 0 drops everything
      restart();
      rom_size = 32'd0;
      send_word(32'h4E000000, a);
      chk("zero_ack", a, 1);
      chk("zero_wd", words_dropped, 1);
      chk("zero_bl", bytes_loaded, 0);
      repeat (100) @(negedge clk);
      chk("zero_nostrobe", sq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
